// File: rtl/ram_arbiter_if.sv
// Cache RAM-side handshake bundle: level Lesen/Schreiben request held until a
// one-cycle DatenGelesen/DatenGeschrieben acknowledge. master = requesting side.
interface ram_arbiter_if;
    logic        Lesen;
    logic        Schreiben;
    logic [31:0] Adresse;
    logic [31:0] SchreibDaten;
    logic [31:0] LesDaten;
    logic        DatenGelesen;
    logic        DatenGeschrieben;

    modport master (
        output Lesen, Schreiben, Adresse, SchreibDaten,
        input  LesDaten, DatenGelesen, DatenGeschrieben
    );

    modport slave (
        input  Lesen, Schreiben, Adresse, SchreibDaten,
        output LesDaten, DatenGelesen, DatenGeschrieben
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between two caches, grant locked per burst.
// Optional `define ARB_TIMEOUT_EN force-releases a grant idle for TIMEOUT cycles.
module ram_arbiter #(
    parameter int unsigned BLOCKSIZEBITS = 2,
    parameter int unsigned TIMEOUT       = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    ram_arbiter_if.slave  A,
    ram_arbiter_if.slave  B,
    ram_arbiter_if.master RAM
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        GRANT_A = 3'b010,
        GRANT_B = 3'b100
    } state_t;

    state_t                   state;
    logic [BLOCKSIZEBITS-1:0] beat;
    logic                     last_b;
    logic                     a_req;
    logic                     b_req;
    logic                     ram_ack;
    logic                     gnt_req;
    logic                     to_hit;

    always_comb begin
        a_req   = A.Lesen | A.Schreiben;
        b_req   = B.Lesen | B.Schreiben;
        ram_ack = RAM.DatenGelesen | RAM.DatenGeschrieben;
        gnt_req = 1'b0;
        if (state == GRANT_A) gnt_req = a_req;
        if (state == GRANT_B) gnt_req = b_req;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Release fires on the edge where the idle count would reach TIMEOUT.
    always_comb to_hit = (state != IDLE) && !gnt_req && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            idle_cnt <= '0;
        else if (state == IDLE || gnt_req || to_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    always_comb to_hit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            beat   <= '0;
            last_b <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    // Tie goes to whichever side was not served last.
                    if (a_req && (!b_req || last_b))
                        state <= GRANT_A;
                    else if (b_req)
                        state <= GRANT_B;
                end
                GRANT_A, GRANT_B: begin
                    if (to_hit) begin
                        state  <= IDLE;
                        beat   <= '0;
                        last_b <= (state == GRANT_B);
                    end else if (ram_ack) begin
                        beat <= beat + 1'b1;
                        if (beat == '1) begin
                            state  <= IDLE;
                            last_b <= (state == GRANT_B);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request path and acknowledge routing are combinational so a beat costs no extra cycle.
    always_comb begin
        RAM.Lesen          = 1'b0;
        RAM.Schreiben      = 1'b0;
        RAM.Adresse        = '0;
        RAM.SchreibDaten   = '0;
        A.DatenGelesen     = 1'b0;
        A.DatenGeschrieben = 1'b0;
        B.DatenGelesen     = 1'b0;
        B.DatenGeschrieben = 1'b0;
        A.LesDaten         = RAM.LesDaten;
        B.LesDaten         = RAM.LesDaten;
        case (state)
            GRANT_A: begin
                RAM.Lesen          = A.Lesen;
                RAM.Schreiben      = A.Schreiben;
                RAM.Adresse        = A.Adresse;
                RAM.SchreibDaten   = A.SchreibDaten;
                A.DatenGelesen     = RAM.DatenGelesen;
                A.DatenGeschrieben = RAM.DatenGeschrieben;
            end
            GRANT_B: begin
                RAM.Lesen          = B.Lesen;
                RAM.Schreiben      = B.Schreiben;
                RAM.Adresse        = B.Adresse;
                RAM.SchreibDaten   = B.SchreibDaten;
                B.DatenGelesen     = RAM.DatenGelesen;
                B.DatenGeschrieben = RAM.DatenGeschrieben;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, single burst, tie-break, gaps, ordering, async reset.
module tb_ram_arbiter;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    ram_arbiter_if ifa ();
    ram_arbiter_if ifb ();
    ram_arbiter_if ifr ();

    ram_arbiter #(
        .BLOCKSIZEBITS(2),
        .TIMEOUT      (8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .A    (ifa),
        .B    (ifb),
        .RAM  (ifr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    task automatic clear_inputs();
        ifa.Lesen = 1'b0; ifa.Schreiben = 1'b0; ifa.Adresse = '0; ifa.SchreibDaten = '0;
        ifb.Lesen = 1'b0; ifb.Schreiben = 1'b0; ifb.Adresse = '0; ifb.SchreibDaten = '0;
        ifr.LesDaten = '0; ifr.DatenGelesen = 1'b0; ifr.DatenGeschrieben = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        clear_inputs();
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1'b0;
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd5; ifa.SchreibDaten = 32'h55;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL reset_ram_lesen got %b want 0", ifr.Lesen);
        end
        checks++;
        if (ifr.Adresse !== 32'd0 || ifr.SchreibDaten !== 32'd0 || ifr.Schreiben !== 1'b0) begin
            errors++; $display("FAIL reset_ram_bus got adr %h wd %h wr %b want 0", ifr.Adresse, ifr.SchreibDaten, ifr.Schreiben);
        end
        Reset = 1'b1;
        ifa.Lesen = 1'b0;
        @(negedge Clock);
        ifr.DatenGelesen = 1'b1;
        #1;
        checks++;
        if (ifa.DatenGelesen !== 1'b0 || ifb.DatenGelesen !== 1'b0) begin
            errors++; $display("FAIL idle_ack_ignored got a %b b %b want 0 0", ifa.DatenGelesen, ifb.DatenGelesen);
        end
        @(negedge Clock);
        ifr.DatenGelesen = 1'b0;
    endtask

    task automatic test_single_read();
        apply_reset();
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd100;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL single_decision_cycle got %b want 0", ifr.Lesen);
        end
        @(negedge Clock);
        for (int k = 0; k < 4; k++) begin
            ifa.Adresse = 32'(100 + k);
            #1;
            checks++;
            if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'(100 + k)) begin
                errors++; $display("FAIL single_beat_addr got %b %0d want 1 %0d", ifr.Lesen, ifr.Adresse, 100 + k);
            end
            @(negedge Clock);
            @(negedge Clock);
            ifr.LesDaten = 32'(32'hA000 + k);
            ifr.DatenGelesen = 1'b1;
            #1;
            checks++;
            if (ifa.DatenGelesen !== 1'b1 || ifb.DatenGelesen !== 1'b0 || ifa.LesDaten !== 32'(32'hA000 + k)) begin
                errors++; $display("FAIL single_ack got a %b b %b d %h want 1 0 %h",
                                   ifa.DatenGelesen, ifb.DatenGelesen, ifa.LesDaten, 32'hA000 + k);
            end
            @(negedge Clock);
            ifr.DatenGelesen = 1'b0;
        end
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0 || ifr.Adresse !== 32'd0) begin
            errors++; $display("FAIL single_back_to_idle got %b %0d want 0 0", ifr.Lesen, ifr.Adresse);
        end
        ifa.Lesen = 1'b0;
    endtask

    task automatic test_tie();
        apply_reset();
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd200;
        ifb.Lesen = 1'b1; ifb.Adresse = 32'd300;
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Adresse !== 32'd200) begin
            errors++; $display("FAIL tie_first_a got %0d want 200", ifr.Adresse);
        end
        for (int k = 0; k < 4; k++) begin
            ifr.DatenGelesen = 1'b1;
            #1;
            checks++;
            if (ifa.DatenGelesen !== 1'b1 || ifb.DatenGelesen !== 1'b0) begin
                errors++; $display("FAIL tie_a_ack got a %b b %b want 1 0", ifa.DatenGelesen, ifb.DatenGelesen);
            end
            @(negedge Clock);
        end
        ifr.DatenGelesen = 1'b0;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0 || ifr.Adresse !== 32'd0) begin
            errors++; $display("FAIL tie_gap_idle got %b %0d want 0 0", ifr.Lesen, ifr.Adresse);
        end
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Adresse !== 32'd300 || ifr.Lesen !== 1'b1) begin
            errors++; $display("FAIL tie_then_b got %b %0d want 1 300", ifr.Lesen, ifr.Adresse);
        end
        for (int k = 0; k < 4; k++) begin
            ifr.DatenGelesen = 1'b1;
            #1;
            checks++;
            if (ifb.DatenGelesen !== 1'b1 || ifa.DatenGelesen !== 1'b0) begin
                errors++; $display("FAIL tie_b_ack got a %b b %b want 0 1", ifa.DatenGelesen, ifb.DatenGelesen);
            end
            @(negedge Clock);
        end
        ifr.DatenGelesen = 1'b0;
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Adresse !== 32'd200) begin
            errors++; $display("FAIL tie_next_a got %0d want 200", ifr.Adresse);
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        ifb.Schreiben = 1'b1; ifb.Adresse = 32'd400; ifb.SchreibDaten = 32'hB0;
        @(negedge Clock);
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd500;
        for (int k = 0; k < 4; k++) begin
            ifb.Schreiben = 1'b1;
            ifb.Adresse = 32'(400 + k);
            ifb.SchreibDaten = 32'(32'hB0 + k);
            #1;
            checks++;
            if (ifr.Schreiben !== 1'b1 || ifr.Lesen !== 1'b0 || ifr.Adresse !== 32'(400 + k)
                || ifr.SchreibDaten !== 32'(32'hB0 + k)) begin
                errors++; $display("FAIL gaps_b_write got w %b r %b adr %0d wd %h want 1 0 %0d %h",
                                   ifr.Schreiben, ifr.Lesen, ifr.Adresse, ifr.SchreibDaten, 400 + k, 32'hB0 + k);
            end
            ifr.DatenGeschrieben = 1'b1;
            #1;
            checks++;
            if (ifb.DatenGeschrieben !== 1'b1 || ifa.DatenGeschrieben !== 1'b0 || ifa.DatenGelesen !== 1'b0) begin
                errors++; $display("FAIL gaps_ack_route got b %b a %b %b want 1 0 0",
                                   ifb.DatenGeschrieben, ifa.DatenGeschrieben, ifa.DatenGelesen);
            end
            @(negedge Clock);
            ifr.DatenGeschrieben = 1'b0;
            if (k < 3) begin
                ifb.Schreiben = 1'b0;
                #1;
                checks++;
                if (ifr.Schreiben !== 1'b0 || ifr.Lesen !== 1'b0) begin
                    errors++; $display("FAIL gaps_grant_held got w %b r %b want 0 0", ifr.Schreiben, ifr.Lesen);
                end
                @(negedge Clock);
            end
        end
        ifb.Schreiben = 1'b0;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL gaps_idle got %b want 0", ifr.Lesen);
        end
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'd500) begin
            errors++; $display("FAIL gaps_then_a got %b %0d want 1 500", ifr.Lesen, ifr.Adresse);
        end
    endtask

    task automatic test_wb_fill();
        apply_reset();
        ifb.Schreiben = 1'b1; ifb.Adresse = 32'd700;
        @(negedge Clock);
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd600;
        for (int k = 0; k < 4; k++) begin
            ifr.DatenGeschrieben = 1'b1;
            #1;
            checks++;
            if (ifb.DatenGeschrieben !== 1'b1 || ifr.Schreiben !== 1'b1) begin
                errors++; $display("FAIL wbfill_wb got ack %b w %b want 1 1", ifb.DatenGeschrieben, ifr.Schreiben);
            end
            @(negedge Clock);
        end
        ifr.DatenGeschrieben = 1'b0;
        ifb.Schreiben = 1'b0;
        ifb.Lesen = 1'b1;
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'd600) begin
            errors++; $display("FAIL wbfill_a_between got %b %0d want 1 600", ifr.Lesen, ifr.Adresse);
        end
        for (int k = 0; k < 4; k++) begin
            ifr.DatenGelesen = 1'b1;
            #1;
            checks++;
            if (ifa.DatenGelesen !== 1'b1 || ifb.DatenGelesen !== 1'b0) begin
                errors++; $display("FAIL wbfill_a_ack got a %b b %b want 1 0", ifa.DatenGelesen, ifb.DatenGelesen);
            end
            @(negedge Clock);
        end
        ifr.DatenGelesen = 1'b0;
        ifa.Lesen = 1'b0;
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'd700) begin
            errors++; $display("FAIL wbfill_b_fill got %b %0d want 1 700", ifr.Lesen, ifr.Adresse);
        end
        ifb.Lesen = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd800;
        @(negedge Clock);
        for (int k = 0; k < 2; k++) begin
            ifr.DatenGelesen = 1'b1;
            @(negedge Clock);
        end
        #2;
        Reset = 1'b0;
        ifr.DatenGelesen = 1'b1;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0 || ifr.Adresse !== 32'd0 || ifa.DatenGelesen !== 1'b0) begin
            errors++; $display("FAIL async_reset_outputs got r %b adr %0d ack %b want 0 0 0",
                               ifr.Lesen, ifr.Adresse, ifa.DatenGelesen);
        end
        ifr.DatenGelesen = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL async_reset_idle got %b want 0", ifr.Lesen);
        end
        @(negedge Clock);
        for (int k = 0; k < 3; k++) begin
            ifr.DatenGelesen = 1'b1;
            @(negedge Clock);
        end
        ifr.DatenGelesen = 1'b0;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'd800) begin
            errors++; $display("FAIL async_reset_beat_zero got %b %0d want 1 800", ifr.Lesen, ifr.Adresse);
        end
        ifr.DatenGelesen = 1'b1;
        @(negedge Clock);
        ifr.DatenGelesen = 1'b0;
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL async_reset_full_burst got %b want 0", ifr.Lesen);
        end
        ifa.Lesen = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        ifa.Lesen = 1'b1; ifa.Adresse = 32'd900;
        @(negedge Clock);
        ifa.Lesen = 1'b0;
        ifb.Lesen = 1'b1; ifb.Adresse = 32'd950;
        for (int k = 0; k < 8; k++) @(negedge Clock);
        #1;
        checks++;
        if (ifr.Lesen !== 1'b0) begin
            errors++; $display("FAIL timeout_released_idle got %b want 0", ifr.Lesen);
        end
        @(negedge Clock);
        #1;
        checks++;
        if (ifr.Lesen !== 1'b1 || ifr.Adresse !== 32'd950) begin
            errors++; $display("FAIL timeout_b_granted got %b %0d want 1 950", ifr.Lesen, ifr.Adresse);
        end
        ifb.Lesen = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_tie();
        test_gaps();
        test_wb_fill();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
